coil_sample_player: RTL

//  Downstream consumer of the 16-bit sample FIFO output port. Pulls coil-drive samples with the read/waitrequest

---
 rtl/coil_player_pkg.sv | 9 +
 rtl/coil_gain_sat.sv | 31 +++
 rtl/coil_sample_player.sv | 69 ++++++
 3 files changed

// File: rtl/coil_player_pkg.sv
// coil_player_pkg: shared width, idle code, FSM states and Q1.15 saturation helper
package coil_player_pkg;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] IDLE_CODE = 16'h8000;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  function automatic logic [DATA_W-1:0] sat16(input logic signed [32:0] v);
    return v > 33'sd32767 ? 16'h7fff : v < -33'sd32768 ? 16'h8000 : v[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/coil_gain_sat.sv
// coil_gain_sat: two-stage gain multiply, then floor-shift, saturate and offset-encode
module coil_gain_sat
  import coil_player_pkg::*;
#(
  parameter logic [DATA_W-1:0] MASK = IDLE_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [15:0]       gain,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_strobe
);
  logic signed [32:0] prod;
  logic signed [32:0] shifted;
  logic               prod_valid;
  always_comb shifted = prod >>> 15;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      dac_data   <= MASK;
      dac_strobe <= 1'b0;
    end else begin
      prod       <= 33'($signed(sample)) * 33'($signed({1'b0, gain}));
      prod_valid <= in_valid;
      dac_strobe <= prod_valid;
      if (prod_valid) dac_data <= sat16(shifted) ^ MASK;
    end
endmodule

// File: rtl/coil_sample_player.sv
// coil_sample_player: pulls FIFO samples, paces them at rate_div+1 clocks, scales and drives the coil DAC
module coil_sample_player
  import coil_player_pkg::*;
#(
  parameter int DIV_W         = 16,
  parameter bit OFFSET_BINARY = 1'b1,
  parameter bit UNDERRUN_HOLD = 1'b0
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [15:0]       gain,
  input  logic              clr_status,
  output logic              fifo_out_read,
  input  logic [DATA_W-1:0] fifo_out_readdata,
  input  logic              fifo_out_waitrequest,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_strobe,
  output logic              running,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);
  localparam logic [DATA_W-1:0] MASK = OFFSET_BINARY ? IDLE_CODE : '0;
  state_t            state, state_n;
  logic [DATA_W-1:0] stage, last, sample;
  logic              stage_valid, accept, tick, consume, starve, stop;
  logic [DIV_W-1:0]  cnt;
  always_comb begin
    state_n = !enable ? IDLE : state == IDLE ? PRIME : (state == PRIME && stage_valid) ? RUN : state;
    stop    = !enable && state != IDLE;
    tick    = enable && state == RUN && cnt == '0;
    consume = tick && stage_valid;
    starve  = tick && !stage_valid;
    fifo_out_read = state != IDLE && (!stage_valid || consume);
    accept  = fifo_out_read && !fifo_out_waitrequest;
    // the disable cycle pushes a zero so the last strobe lands on the idle code
    sample  = consume ? stage : (stop || !UNDERRUN_HOLD) ? '0 : last;
    running = state == RUN;
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      state        <= IDLE;
      stage        <= '0;
      stage_valid  <= 1'b0;
      last         <= '0;
      cnt          <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state       <= state_n;
      stage_valid <= state_n == IDLE ? 1'b0 : accept ? 1'b1 : consume ? 1'b0 : stage_valid;
      if (accept) stage <= fifo_out_readdata;
      if (consume) last <= stage;
      cnt          <= state == PRIME ? '0 : tick ? rate_div : cnt != '0 ? cnt - DIV_W'(1) : cnt;
      underrun     <= starve || (underrun && !clr_status);
      underrun_cnt <= starve ? (clr_status ? 16'd1 : underrun_cnt == 16'hffff ? underrun_cnt : underrun_cnt + 16'd1)
                    : clr_status ? '0 : underrun_cnt;
    end
  coil_gain_sat #(.MASK(MASK)) u_gain (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .in_valid  (tick || stop),
    .sample    (sample),
    .gain      (gain),
    .dac_data  (dac_data),
    .dac_strobe(dac_strobe)
  );
endmodule
